// File: rtl/ptp_up_master.sv
// ptp_up_master: queued command master driving the PTP core micro-processor register bus.
// Optional strobe statistics counters are built when PTP_UP_MASTER_STAT_EN is defined.
module ptp_up_master #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic          up_clk,
  input  logic          up_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          up_wr,
  output logic          up_rd,
  output logic [AW-1:0] up_addr,
  output logic [DW-1:0] up_data_wr,
`ifdef PTP_UP_MASTER_STAT_EN
  output logic [15:0]   stat_wr_cnt,
  output logic [15:0]   stat_rd_cnt,
`endif
  input  logic [DW-1:0] up_data_rd
);

  localparam int unsigned PW         = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT   = DEPTH[PW:0];
  localparam logic [15:0] SETUP_INIT = 16'(SETUP_CYC - 1);
  localparam logic [15:0] RDLAT_INIT = 16'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, POST, WAIT, RESP, HOLD} state_t;

  state_t        state, state_n;
  logic [1:0]    fifo_op   [DEPTH];
  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_n;
  logic          push, pop;

  logic [15:0]   cnt, cnt_n;
  logic          is_rd, is_rd_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n;
  logic          wr_n, rd_n;
  logic          rsp_free;
  logic          rsp_valid_n;
  logic [AW-1:0] rsp_addr_n;
  logic [DW-1:0] rsp_data_n;
  logic [DW-1:0] rbuf, rbuf_n;

  assign push = cmd_valid && cmd_ready;
  assign busy = (state != IDLE) || (count != '0);

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (pop && !push) count_n = count - 1'b1;
  end

  always_ff @(posedge up_clk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= cmd_op;
      fifo_addr[wr_ptr] <= cmd_addr;
      fifo_data[wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge up_clk) begin
    if (!up_rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cmd_ready  <= 1'b1;
      cnt        <= '0;
      is_rd      <= 1'b0;
      up_wr      <= 1'b0;
      up_rd      <= 1'b0;
      up_addr    <= '0;
      up_data_wr <= '0;
      rsp_valid  <= 1'b0;
      rsp_addr   <= '0;
      rsp_data   <= '0;
      rbuf       <= '0;
    end else begin
      state      <= state_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_n;
      cmd_ready  <= (count_n != FULL_CNT);
      cnt        <= cnt_n;
      is_rd      <= is_rd_n;
      up_wr      <= wr_n;
      up_rd      <= rd_n;
      up_addr    <= addr_n;
      up_data_wr <= wdata_n;
      rsp_valid  <= rsp_valid_n;
      rsp_addr   <= rsp_addr_n;
      rsp_data   <= rsp_data_n;
      rbuf       <= rbuf_n;
    end
  end

  // Strobes are registered from the state decision, so each is high for exactly the STROBE cycle.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    is_rd_n     = is_rd;
    pop         = 1'b0;
    addr_n      = up_addr;
    wdata_n     = up_data_wr;
    wr_n        = 1'b0;
    rd_n        = 1'b0;
    rsp_free    = !rsp_valid || rsp_ready;
    rsp_valid_n = rsp_valid && !rsp_ready;
    rsp_addr_n  = rsp_addr;
    rsp_data_n  = rsp_data;
    rbuf_n      = rbuf;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop    = 1'b1;
          addr_n = fifo_addr[rd_ptr];
          case (fifo_op[rd_ptr])
            2'b00: begin
              wdata_n = fifo_data[rd_ptr];
              is_rd_n = 1'b0;
              cnt_n   = SETUP_INIT;
              state_n = SETUP;
            end
            2'b01: begin
              is_rd_n = 1'b1;
              cnt_n   = SETUP_INIT;
              state_n = SETUP;
            end
            2'b10: begin
              cnt_n   = fifo_data[rd_ptr][15:0];
              state_n = HOLD;
            end
            default: state_n = IDLE;
          endcase
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          wr_n    = !is_rd;
          rd_n    = is_rd;
          state_n = STROBE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (is_rd) begin
          cnt_n   = RDLAT_INIT;
          state_n = WAIT;
        end else begin
          state_n = POST;
        end
      end
      POST: state_n = IDLE;
      WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (rsp_free) begin
          rsp_valid_n = 1'b1;
          rsp_addr_n  = up_addr;
          rsp_data_n  = up_data_rd;
          state_n     = IDLE;
        end else begin
          rbuf_n  = up_data_rd;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_free) begin
          rsp_valid_n = 1'b1;
          rsp_addr_n  = up_addr;
          rsp_data_n  = rbuf;
          state_n     = IDLE;
        end
      end
      HOLD: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef PTP_UP_MASTER_STAT_EN
  always_ff @(posedge up_clk) begin
    if (!up_rst_n) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else begin
      if (up_wr) stat_wr_cnt <= stat_wr_cnt + 1'b1;
      if (up_rd) stat_rd_cnt <= stat_rd_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ptp_up_master.sv
// Self-checking bench for ptp_up_master: directed timing cases plus randomized traffic
// against a transaction-level model (command order, read-data timing, response order).
module tb_ptp_up_master;
  localparam int unsigned AW        = 8;
  localparam int unsigned DW        = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned SETUP_CYC = 1;
  localparam int unsigned RD_LAT    = 2;

  logic          up_clk = 1'b0;
  logic          up_rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          up_wr;
  logic          up_rd;
  logic [AW-1:0] up_addr;
  logic [DW-1:0] up_data_wr;
  logic [DW-1:0] up_data_rd = '0;
`ifdef PTP_UP_MASTER_STAT_EN
  logic [15:0]   stat_wr_cnt;
  logic [15:0]   stat_rd_cnt;
`endif

  ptp_up_master #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC), .RD_LAT(RD_LAT)
  ) dut (
    .up_clk(up_clk), .up_rst_n(up_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .busy(busy), .up_wr(up_wr), .up_rd(up_rd), .up_addr(up_addr), .up_data_wr(up_data_wr),
`ifdef PTP_UP_MASTER_STAT_EN
    .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
`endif
    .up_data_rd(up_data_rd)
  );

  always #5 up_clk = ~up_clk;

  typedef struct packed { logic [1:0] op; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } rsp_t;

  cmd_t          cmd_q[$];
  rsp_t          rsp_q[$];
  cmd_t          mon_c;
  rsp_t          mon_r;
  logic [DW-1:0] last_wr = '0;
  logic [DW-1:0] rd_good = '0;
  logic          dir_rd_en = 1'b0;
  logic [DW-1:0] dir_rd_val = '0;
  int unsigned   rd_pend = 0;
  int unsigned   rsp_mode = 0;
  int unsigned   wr_cnt_m = 0;
  int unsigned   rd_cnt_m = 0;
  int unsigned   cyc = 0;
  int unsigned   strobe_cyc_last = 0;
  int unsigned   strobe_cyc_prev = 0;
  logic          prev_strobe = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge up_clk) cyc++;

  // Bus slave + response sink model: valid read data only in the sampling cycle, garbage otherwise.
  always @(negedge up_clk) begin
    if (rd_pend != 0) begin
      rd_pend--;
      up_data_rd = (rd_pend == 0) ? rd_good : $urandom;
    end else begin
      up_data_rd = $urandom;
    end

    if (up_wr || up_rd) begin
      check_val("strobe_exclusive", up_wr && up_rd, 1'b0);
      check_val("strobe_back_to_back", prev_strobe, 1'b0);
      strobe_cyc_prev = strobe_cyc_last;
      strobe_cyc_last = cyc;
      while (cmd_q.size() != 0 && cmd_q[0].op[1]) void'(cmd_q.pop_front());
      check_val("strobe_expected", cmd_q.size() != 0, 1'b1);
      if (cmd_q.size() != 0) begin
        mon_c = cmd_q.pop_front();
        check_val("strobe_kind", up_rd, mon_c.op[0]);
        check_val("strobe_addr", up_addr, mon_c.addr);
        if (!mon_c.op[0]) begin
          check_val("strobe_wdata", up_data_wr, mon_c.data);
          last_wr = mon_c.data;
          wr_cnt_m++;
        end else begin
          check_val("read_keeps_wdata", up_data_wr, last_wr);
          rd_good = dir_rd_en ? dir_rd_val : $urandom;
          rd_pend = RD_LAT;
          rsp_q.push_back({mon_c.addr, rd_good});
          rd_cnt_m++;
        end
      end
    end
    prev_strobe = up_wr || up_rd;

    case (rsp_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
    if (rsp_valid && rsp_ready) begin
      check_val("rsp_expected", rsp_q.size() != 0, 1'b1);
      if (rsp_q.size() != 0) begin
        mon_r = rsp_q.pop_front();
        check_val("rsp_addr", rsp_addr, mon_r.addr);
        check_val("rsp_data", rsp_data, mon_r.data);
      end
    end
  end

  task automatic push_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int unsigned n;
    n = 0;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge up_clk);
      n++;
    end
    check_val("cmd_accept", cmd_ready, 1'b1);
    cmd_q.push_back({op, a, d});
    @(negedge up_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    while ((busy || rsp_q.size() != 0) && n < 2000) begin
      @(negedge up_clk);
      n++;
    end
    check_val(tag, busy, 1'b0);
    check_val({tag, "_rsp"}, rsp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] addrs [6];
    int unsigned   hn;
    int unsigned   k;
    int unsigned   rd_before;
    int unsigned   n;
    logic [1:0]    op;
    logic [DW-1:0] d;

    repeat (3) @(negedge up_clk);
    check_val("rst_cmd_ready", cmd_ready, 1'b1);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_up_wr", up_wr, 1'b0);
    check_val("rst_up_rd", up_rd, 1'b0);
    check_val("rst_up_addr", up_addr, '0);
    check_val("rst_up_data_wr", up_data_wr, '0);
    check_val("rst_rsp_addr", rsp_addr, '0);
    check_val("rst_rsp_data", rsp_data, '0);
    up_rst_n = 1'b1;
    @(negedge up_clk);

    // Single write: accepted at E0, strobe cycle E2-E3, idle again at E4.
    rsp_mode = 1;
    push_cmd(2'b00, 8'h24, 32'hDEADBEEF);
    @(negedge up_clk);
    check_val("wr_addr_e1", up_addr, 8'h24);
    check_val("wr_data_e1", up_data_wr, 32'hDEADBEEF);
    check_val("wr_strobe_e1", up_wr, 1'b0);
    @(negedge up_clk);
    check_val("wr_strobe_e2", up_wr, 1'b1);
    check_val("wr_no_rd_e2", up_rd, 1'b0);
    @(negedge up_clk);
    check_val("wr_strobe_e3", up_wr, 1'b0);
    check_val("wr_busy_e3", busy, 1'b1);
    @(negedge up_clk);
    check_val("wr_busy_e4", busy, 1'b0);

    // Single read: response visible after E5.
    rsp_mode = 0;
    dir_rd_en = 1'b1;
    dir_rd_val = 32'h12345678;
    push_cmd(2'b01, 8'h30, '0);
    repeat (2) @(negedge up_clk);
    check_val("rd_strobe_e2", up_rd, 1'b1);
    repeat (2) @(negedge up_clk);
    check_val("rd_rsp_valid_e4", rsp_valid, 1'b0);
    @(negedge up_clk);
    check_val("rd_rsp_valid_e5", rsp_valid, 1'b1);
    check_val("rd_rsp_addr_e5", rsp_addr, 8'h30);
    check_val("rd_rsp_data_e5", rsp_data, 32'h12345678);
    dir_rd_en = 1'b0;
    rsp_mode = 1;
    wait_idle("rd_drain");
    repeat (2) @(negedge up_clk);
    check_val("rd_rsp_consumed", rsp_valid, 1'b0);

    // Response back-pressure fills the FIFO.
    rsp_mode = 0;
    rd_before = rd_cnt_m;
    for (int i = 0; i < 6; i++) begin
      addrs[i] = 8'($urandom);
      push_cmd(2'b01, addrs[i], '0);
    end
    repeat (20) @(negedge up_clk);
    check_val("bp_cmd_ready", cmd_ready, 1'b0);
    check_val("bp_reads_issued", rd_cnt_m - rd_before, 2);
    check_val("bp_rsp_valid", rsp_valid, 1'b1);
    check_val("bp_rsp_addr", rsp_addr, addrs[0]);
    rsp_mode = 1;
    wait_idle("bp_drain");
    check_val("bp_all_reads", rd_cnt_m - rd_before, 6);

    // Hold and NOP spacing between two writes.
    for (int i = 0; i < 4; i++) begin
      hn = (i == 0) ? 5 : $urandom_range(0, 8);
      push_cmd(2'b00, 8'($urandom), $urandom);
      push_cmd(2'b10, 8'($urandom), {16'($urandom), 16'(hn)});
      push_cmd(2'b00, 8'($urandom), $urandom);
      wait_idle("hold_drain");
      check_val("hold_gap", strobe_cyc_last - strobe_cyc_prev, SETUP_CYC + hn + 5);
    end
    push_cmd(2'b00, 8'h01, $urandom);
    push_cmd(2'b11, 8'h02, $urandom);
    push_cmd(2'b00, 8'h03, $urandom);
    wait_idle("nop_drain");
    check_val("nop_gap", strobe_cyc_last - strobe_cyc_prev, SETUP_CYC + 4);
    push_cmd(2'b00, 8'h04, $urandom);
    push_cmd(2'b00, 8'h05, $urandom);
    wait_idle("ww_drain");
    check_val("ww_gap", strobe_cyc_last - strobe_cyc_prev, SETUP_CYC + 3);

    // Reset while the read strobe is high.
    push_cmd(2'b01, 8'h55, '0);
    n = 0;
    while (!up_rd && n < 20) begin
      @(negedge up_clk);
      n++;
    end
    check_val("mid_rst_rd_seen", up_rd, 1'b1);
    up_rst_n = 1'b0;
    @(negedge up_clk);
    check_val("mid_rst_up_rd", up_rd, 1'b0);
    check_val("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check_val("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check_val("mid_rst_busy", busy, 1'b0);
    rsp_q.delete();
    cmd_q.delete();
    rd_pend = 0;
    wr_cnt_m = 0;
    rd_cnt_m = 0;
    last_wr = '0;
    up_rst_n = 1'b1;
    repeat (15) @(negedge up_clk);
    check_val("mid_rst_no_rsp", rsp_valid, 1'b0);
    check_val("mid_rst_no_strobe", rd_cnt_m, 0);
`ifdef PTP_UP_MASTER_STAT_EN
    check_val("stat_wr_rst", stat_wr_cnt, 16'(wr_cnt_m));
    check_val("stat_rd_rst", stat_rd_cnt, 16'(rd_cnt_m));
    for (int i = 0; i < 3; i++) push_cmd(2'b00, 8'($urandom), $urandom);
    for (int i = 0; i < 2; i++) push_cmd(2'b01, 8'($urandom), $urandom);
    wait_idle("stat_drain");
    check_val("stat_wr_3", stat_wr_cnt, 16'(wr_cnt_m));
    check_val("stat_rd_2", stat_rd_cnt, 16'(rd_cnt_m));
`endif

    // Randomized traffic with random response back-pressure.
    rsp_mode = 2;
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      op = (k < 4) ? 2'b00 : (k < 8) ? 2'b01 : (k == 8) ? 2'b10 : 2'b11;
      d = $urandom;
      if (op == 2'b10) d[15:0] = 16'($urandom_range(0, 3));
      push_cmd(op, 8'($urandom), d);
      repeat ($urandom_range(0, 2)) @(negedge up_clk);
    end
    wait_idle("rand_drain");
    while (cmd_q.size() != 0 && cmd_q[0].op[1]) void'(cmd_q.pop_front());
    check_val("rand_cmds_consumed", cmd_q.size(), 0);
`ifdef PTP_UP_MASTER_STAT_EN
    check_val("stat_wr_final", stat_wr_cnt, 16'(wr_cnt_m));
    check_val("stat_rd_final", stat_rd_cnt, 16'(rd_cnt_m));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
